mux_rr_stream: RTL

- Parametrised N-channel, W-bit streaming multiplexer with registered output.
- Successor to the team's fixed 4:1 combinational mux.
- Adds per-channel valid/ready handshakes, round-robin or fixed-priority arbitration, a manual-select override, and one output register stage.
- Sits between several producer blocks and a single shared downstream consumer.

---
 rtl/mux_rr_stream.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_rr_stream.sv
// N-channel, W-bit streaming multiplexer with valid/ready handshakes on every channel.
// It arbitrates by round-robin or fixed priority, supports a manual-select override and has one registered output stage.
module mux_rr_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr;
    logic                load_en;
    logic                xfer;
    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    gsel;
    logic [SEL_W-1:0]    ptr_next;
    logic [WIDTH-1:0]    gdata;

    // Output register can take a word when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Eligible set; an out-of-range force_sel matches no channel, so nothing is granted.
    always_comb begin : eligible
        elig = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (force_en) begin
                elig[i] = in_valid[i] && (force_sel == SEL_W'(i));
            end else begin
                elig[i] = in_valid[i];
            end
        end
    end

    // Circular scan from the start index; fixed priority is just a scan that always starts at 0.
    always_comb begin : arbiter
        logic [SEL_W:0]   start;
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        logic             found;
        start = mode ? '0 : {1'b0, ptr};
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        grant = '0;
        gsel  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            sum = start + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(CHANNELS)) begin
                sum = sum - (SEL_W+1)'(CHANNELS);
            end
            idx = sum[SEL_W-1:0];
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gsel       = idx;
            end
        end
    end

    always_comb begin : data_mux
        gdata = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (gsel == SEL_W'(CHANNELS - 1)) ? '0 : gsel + SEL_W'(1);
    assign in_ready = grant & {CHANNELS{load_en & ~rst}};
    assign xfer     = |in_ready;

    // The pointer follows every transfer, so returning to round-robin stays fair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gsel;
                ptr       <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
